// File: rtl/des_key_schedule.sv
// des_key_schedule: iterative DES subkey generator, encrypt or decrypt order, one subkey per handshake
module des_key_schedule #(
  parameter bit CHECK_PARITY = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] key,
  input  logic        decrypt,
  output logic        busy,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [47:0] subkey,
  output logic [3:0]  round,
  output logic        done,
  output logic        parity_err
);
  typedef enum logic [1:0] {idle, present, fin} state_t;
  localparam int pc1_tab [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int pc2_tab [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  // bit r set means round r (0-based) rotates by two positions instead of one
  localparam logic [15:0] two_shift = 16'h7efc;
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    for (int i = 0; i < 56; i++) r[55-i] = k[64-pc1_tab[i]];
    return r;
  endfunction
  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    for (int i = 0; i < 48; i++) r[47-i] = cd[56-pc2_tab[i]];
    return r;
  endfunction
  function automatic logic [27:0] rotl(input logic [27:0] x, input logic two);
    return two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction
  function automatic logic [27:0] rotr(input logic [27:0] x, input logic two);
    return two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction
  state_t      state, nxt;
  logic [27:0] c, d;
  logic [3:0]  count;
  logic        dir;
  logic [55:0] cd0;
  logic [3:0]  round_inc;
  logic        par_err;
  assign cd0 = pc1(key);
  assign round_inc = round + 4'd1;
  assign busy = state == present;
  assign subkey_valid = state == present;
  assign done = state == fin;
  assign subkey = pc2({c, d});
  // a byte with an even number of ones flags a parity error
  always_comb begin
    par_err = 1'b0;
    for (int b = 0; b < 8; b++) par_err = par_err | ~^key[8*b +: 8];
    par_err = par_err & CHECK_PARITY;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= idle;
    else state <= nxt;
  // next state: leave PRESENT only when the sixteenth subkey is taken
  always_comb begin
    nxt = idle;
    nxt = state == idle    ? (start ? present : idle) :
          state == present ? ((subkey_ready && count == 4'd15) ? fin : present) : idle;
  end
  // C/D rotation, round/count tracking and key load
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      c <= '0;
      d <= '0;
      count <= '0;
      round <= '0;
      dir <= 1'b0;
      parity_err <= 1'b0;
    end else if (state == idle && start) begin
      dir <= decrypt;
      c <= decrypt ? cd0[55:28] : rotl(cd0[55:28], 1'b0);
      d <= decrypt ? cd0[27:0] : rotl(cd0[27:0], 1'b0);
      round <= decrypt ? 4'd15 : 4'd0;
      count <= '0;
      parity_err <= par_err;
    end else if (state == present && subkey_ready && count != 4'd15) begin
      c <= dir ? rotr(c, two_shift[round]) : rotl(c, two_shift[round_inc]);
      d <= dir ? rotr(d, two_shift[round]) : rotl(d, two_shift[round_inc]);
      round <= dir ? round - 4'd1 : round_inc;
      count <= count + 4'd1;
    end
endmodule

// File: tb/tb_des_key_schedule.sv
// tb_des_key_schedule: scoreboard bench comparing DES subkeys against a table-driven reference model
module tb_des_key_schedule;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [63:0] key = '0;
  logic        decrypt = 1'b0;
  logic        subkey_ready = 1'b0;
  logic        busy, subkey_valid, done, parity_err;
  logic [47:0] subkey;
  logic [3:0]  round;

  des_key_schedule #(.CHECK_PARITY(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key), .decrypt(decrypt),
    .busy(busy), .subkey_valid(subkey_valid), .subkey_ready(subkey_ready),
    .subkey(subkey), .round(round), .done(done), .parity_err(parity_err));

  always #5 clk = ~clk;

  localparam logic [63:0] fips_key = 64'h133457799BBCDFF1;
  int pc1_t [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  int pc2_t [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  int shifts [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  typedef struct {
    logic [47:0] sk;
    logic [3:0]  rd;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int passes = 0;
  int hs = 0;
  int vcnt = 0;
  int done_cnt = 0;
  bit rand_ready = 1'b0;
  logic [47:0] first_sk, last_sk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // subkey n (1..16): C0/D0 rotated left by the cumulative shift, then PC-2
  function automatic logic [47:0] model(input logic [63:0] k, input int n);
    int s = 0;
    logic c0 [28];
    logic d0 [28];
    logic cd [56];
    logic [47:0] r;
    for (int i = 0; i < n; i++) s += shifts[i];
    for (int i = 0; i < 28; i++) begin
      c0[i] = k[64-pc1_t[i]];
      d0[i] = k[64-pc1_t[28+i]];
    end
    for (int i = 0; i < 28; i++) begin
      cd[i] = c0[(i+s)%28];
      cd[28+i] = d0[(i+s)%28];
    end
    for (int j = 0; j < 48; j++) r[47-j] = cd[pc2_t[j]-1];
    return r;
  endfunction

  function automatic logic model_par(input logic [63:0] k);
    logic e = 1'b0;
    for (int b = 0; b < 8; b++) if ($countones(k[8*b +: 8]) % 2 == 0) e = 1'b1;
    return e;
  endfunction

  // monitor: every valid cycle must present the head of the scoreboard
  always @(negedge clk) if (rst_n) begin
    if (subkey_valid) begin
      vcnt++;
      if (q.size() == 0) check("unexpected_valid", subkey_valid, 1'b0);
      else begin
        check("subkey", subkey, q[0].sk);
        check("round", round, q[0].rd);
        if (subkey_ready) begin
          if (hs == 0) first_sk = subkey;
          last_sk = subkey;
          hs++;
          void'(q.pop_front());
        end
      end
    end
    if (done) begin
      done_cnt++;
      check("done_after_16", hs, 16);
      check("busy_at_done", busy, 1'b0);
      check("queue_empty_at_done", q.size(), 0);
    end
  end

  initial forever begin
    @(posedge clk);
    #1 subkey_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // disturb: 0 none, 1 start pulse at round 5, 2 reset at round 8
  task automatic run(input logic [63:0] k, input bit dec, input bit rnd, input int disturb);
    int dc;
    int cyc;
    q.delete();
    hs = 0;
    vcnt = 0;
    if (dec) for (int i = 15; i >= 0; i--) q.push_back('{sk: model(k, i + 1), rd: 4'(i)});
    else for (int i = 0; i < 16; i++) q.push_back('{sk: model(k, i + 1), rd: 4'(i)});
    rand_ready = rnd;
    dc = done_cnt;
    @(posedge clk);
    #1 start = 1'b1; key = k; decrypt = dec;
    @(posedge clk);
    #1 start = 1'b0; key = {$urandom, $urandom}; decrypt = ~dec;
    @(negedge clk);
    check("valid_latency", subkey_valid, 1'b1);
    check("busy_after_start", busy, 1'b1);
    check("parity_err", parity_err, model_par(k));
    if (disturb != 0) begin
      cyc = 0;
      while (!(subkey_valid && round == (disturb == 1 ? 4'd5 : 4'd8)) && cyc < 100) begin
        @(negedge clk);
        cyc++;
      end
      check("reach_round", cyc < 100, 1'b1);
      if (disturb == 1) begin
        @(posedge clk);
        #1 start = 1'b1; key = ~k; decrypt = ~dec;
        @(posedge clk);
        #1 start = 1'b0;
      end else begin
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_valid", subkey_valid, 1'b0);
        check("rst_subkey", subkey, 48'h0);
        check("rst_round", round, 4'h0);
        check("rst_done", done, 1'b0);
        check("rst_parity", parity_err, 1'b0);
        q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        check("no_done_after_reset", done_cnt, dc);
        rand_ready = 1'b0;
        return;
      end
    end
    cyc = 0;
    while (done_cnt == dc && cyc < 400) begin
      @(posedge clk);
      cyc++;
    end
    check("done_seen", done_cnt - dc, 1);
    @(negedge clk);
    check("done_single_pulse", done, 1'b0);
    check("handshakes", hs, 16);
    if (!rnd) check("valid_cycles", vcnt, 16);
    rand_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("init_busy", busy, 1'b0);
    check("init_valid", subkey_valid, 1'b0);
    check("init_subkey", subkey, 48'h0);
    check("init_round", round, 4'h0);
    check("init_done", done, 1'b0);
    check("init_parity", parity_err, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    run(fips_key, 1'b0, 1'b0, 0);
    check("enc_first", first_sk, 48'h1B02EFFC7072);
    check("enc_last", last_sk, 48'hCB3D8B0E17F5);
    run(fips_key, 1'b1, 1'b0, 0);
    check("dec_first", first_sk, 48'hCB3D8B0E17F5);
    check("dec_last", last_sk, 48'h1B02EFFC7072);
    run(fips_key ^ 64'h1, 1'b0, 1'b0, 0);
    check("par_key_first", first_sk, 48'h1B02EFFC7072);
    check("par_key_last", last_sk, 48'hCB3D8B0E17F5);
    run(fips_key, 1'b1, 1'b1, 0);
    for (int i = 0; i < 6; i++) run({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b1, 0);
    run({$urandom, $urandom}, 1'b0, 1'b0, 1);
    run({$urandom, $urandom}, 1'b1, 1'b0, 1);
    run(fips_key ^ 64'h1, 1'b0, 1'b0, 2);
    run(fips_key, 1'b0, 1'b0, 0);
    check("post_reset_first", first_sk, 48'h1B02EFFC7072);
    run(fips_key ^ 64'h1, 1'b1, 1'b0, 2);
    run({$urandom, $urandom}, 1'b1, 1'b1, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
